bw_erode: RTL and testbench

BW_ERODE -- requirements
Module: bw_erode

---
 rtl/morph_pkg.sv | 24 ++
 rtl/bw_line_buffer.sv | 40 ++++
 rtl/bw_erode.sv | 172 +++++++++++++++++
 tb/tb_bw_erode.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/morph_pkg.sv
// -----------------------------------------------------------------------------
// morph_pkg
// Shared widths and types for the binary morphology stages.
//   HCOUNT_W   : width of column counts travelling with each pixel
//   VCOUNT_W   : width of row counts travelling with each pixel
//   FG_COUNT_W : width of the per-frame foreground counter (MORPH_STATS_EN)
//   window_t   : 3x3 binary neighbourhood, indexed [col][row]
//                col 0 = oldest column (h-2), col 2 = newest (h)
//                row 0 = line v-2, row 2 = current line v
// -----------------------------------------------------------------------------
package morph_pkg;

  localparam int HCOUNT_W   = 11;
  localparam int VCOUNT_W   = 10;
  localparam int FG_COUNT_W = 17;

  typedef logic [2:0][2:0] window_t;

  // Erosion of a 3x3 neighbourhood: foreground only if every pixel is set.
  function automatic logic window_and(input window_t w);
    return &w;
  endfunction

endpackage

// File: rtl/bw_line_buffer.sv
// -----------------------------------------------------------------------------
// bw_line_buffer
// One line of 1-bit pixels. Separate read and write addresses so a buffer can
// be written one pipeline stage after it is read. When both ports hit the same
// address on the same edge, the read returns the old contents.
// Contents are never reset.
// Ports:
//   clk_in  : clock, rising edge
//   rd_en   : capture mem[rd_addr] into rd_data
//   rd_addr : read address
//   rd_data : registered read data (holds when rd_en is low)
//   wr_en   : write wr_data into mem[wr_addr]
//   wr_addr : write address
//   wr_data : write data
// -----------------------------------------------------------------------------
module bw_line_buffer #(
  parameter int DEPTH = 320,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_in,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic          wr_data
);

  logic mem [DEPTH];

  always_ff @(posedge clk_in) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/bw_erode.sv
// -----------------------------------------------------------------------------
// bw_erode
// 3x3 binary erosion of a raster-ordered black/white pixel stream.
//
// Stream protocol (inputs and outputs alike): valid-only, no backpressure.
// A beat is transferred on every rising edge where *_valid is high; the
// pixel and its counts are meaningful only on that cycle. Valid may drop for
// any number of cycles between beats; internal state only advances on beats.
//
// Pipeline (2 cycles input valid -> output valid):
//   stage 1 : line buffers read at hcount_in, row v-1 buffer written with
//             pixel_in; pixel and counts registered.
//   stage 2 : row v-2 buffer written with the row v-1 value just read; window
//             shifted; eroded pixel and centre counts registered to outputs.
// Input (h,v) produces the centre (h-1,v-1). Centres on column 0 or row 0 are
// forced to 0 since their window reaches outside the frame.
//
// Parameters: HRES (pixels per line), VRES (lines per frame)
// Ports:
//   clk_in, rst_in (synchronous, active-high)
//   hcount_in, vcount_in, data_valid_in, pixel_in : input stream
//   pixel_out, hcount_out, vcount_out, data_valid_out : eroded stream
// Optional (define MORPH_STATS_EN):
//   fg_count_out    : number of foreground pixels emitted in the last frame
//   count_valid_out : one-cycle pulse with the frame's final output
// -----------------------------------------------------------------------------
module bw_erode
  import morph_pkg::*;
#(
  parameter int HRES = 320,
  parameter int VRES = 240
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [HCOUNT_W-1:0]   hcount_in,
  input  logic [VCOUNT_W-1:0]   vcount_in,
  input  logic                  data_valid_in,
  input  logic                  pixel_in,
  output logic                  pixel_out,
  output logic [HCOUNT_W-1:0]   hcount_out,
  output logic [VCOUNT_W-1:0]   vcount_out,
  output logic                  data_valid_out
`ifdef MORPH_STATS_EN
  ,
  output logic [FG_COUNT_W-1:0] fg_count_out,
  output logic                  count_valid_out
`endif
);

  localparam int AW = $clog2(HRES);

  // A beat presented while reset is high is discarded.
  logic accept;
  assign accept = data_valid_in & ~rst_in;

  // Stage 1 registers
  logic                s1_valid;
  logic                s1_pix;
  logic [HCOUNT_W-1:0] s1_h;
  logic [VCOUNT_W-1:0] s1_v;

  // Line buffer read data, aligned with stage 1
  logic row1_rd;   // row v-1 at s1_h
  logic row2_rd;   // row v-2 at s1_h

  bw_line_buffer #(.DEPTH(HRES), .AW(AW)) u_row1_buf (
    .clk_in  (clk_in),
    .rd_en   (accept),
    .rd_addr (hcount_in[AW-1:0]),
    .rd_data (row1_rd),
    .wr_en   (accept),
    .wr_addr (hcount_in[AW-1:0]),
    .wr_data (pixel_in)
  );

  // The row v-1 value read in stage 1 ages into the row v-2 buffer one cycle
  // later at the same column; the next beat is at a different column, so the
  // delayed write never collides with a read it would affect.
  bw_line_buffer #(.DEPTH(HRES), .AW(AW)) u_row2_buf (
    .clk_in  (clk_in),
    .rd_en   (accept),
    .rd_addr (hcount_in[AW-1:0]),
    .rd_data (row2_rd),
    .wr_en   (s1_valid),
    .wr_addr (s1_h[AW-1:0]),
    .wr_data (row1_rd)
  );

  // Window and next-window computation
  window_t win;
  window_t win_next;
  logic    emit;
  logic    border;
  logic    pix_calc;

  always_comb begin
    win_next    = win;
    win_next[0] = win[1];
    win_next[1] = win[2];
    win_next[2] = {s1_pix, row1_rd, row2_rd};
  end

  assign emit     = s1_valid && (s1_h != '0) && (s1_v != '0);
  // Centre column/row 0 corresponds to input column/row 1.
  assign border   = (s1_h == HCOUNT_W'(1)) || (s1_v == VCOUNT_W'(1));
  assign pix_calc = ~border & window_and(win_next);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s1_valid       <= 1'b0;
      s1_pix         <= 1'b0;
      s1_h           <= '0;
      s1_v           <= '0;
      win            <= '0;
      pixel_out      <= 1'b0;
      hcount_out     <= '0;
      vcount_out     <= '0;
      data_valid_out <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_pix <= pixel_in;
        s1_h   <= hcount_in;
        s1_v   <= vcount_in;
      end
      if (s1_valid) begin
        win <= win_next;
      end
      data_valid_out <= emit;
      if (emit) begin
        pixel_out  <= pix_calc;
        hcount_out <= s1_h - HCOUNT_W'(1);
        vcount_out <= s1_v - VCOUNT_W'(1);
      end
    end
  end

`ifdef MORPH_STATS_EN
  // Per-frame foreground count. Cleared when input (0,0) reaches stage 2;
  // that beat emits nothing so no count is lost. The final centre
  // (HRES-2,VRES-2) comes from input (HRES-1,VRES-1).
  logic [FG_COUNT_W-1:0] fg_cnt;
  logic                  frame_start;
  logic                  frame_last;

  assign frame_start = s1_valid && (s1_h == '0) && (s1_v == '0);
  assign frame_last  = emit && (s1_h == HCOUNT_W'(HRES - 1))
                            && (s1_v == VCOUNT_W'(VRES - 1));

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      fg_cnt          <= '0;
      fg_count_out    <= '0;
      count_valid_out <= 1'b0;
    end else begin
      count_valid_out <= 1'b0;
      if (frame_start) begin
        fg_cnt <= '0;
      end else if (emit && pix_calc) begin
        fg_cnt <= fg_cnt + FG_COUNT_W'(1);
      end
      if (frame_last) begin
        fg_count_out    <= fg_cnt + FG_COUNT_W'(pix_calc);
        count_valid_out <= 1'b1;
      end
    end
  end
`else
  // Statistics disabled: no counter, no extra ports.
`endif

endmodule

// File: tb/tb_bw_erode.sv
// -----------------------------------------------------------------------------
// tb_bw_erode
// Randomised and directed frames for bw_erode at HRES=8, VRES=6. The driver
// pushes the expected centre for every input beat computed directly from the
// stored frame image; a negedge monitor pops and compares each output beat.
// Define MORPH_STATS_EN to also check the per-frame foreground count.
// -----------------------------------------------------------------------------
module tb_bw_erode;
  import morph_pkg::*;

  localparam int HRES = 8;
  localparam int VRES = 6;

  // Clock / reset
  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic                rst_in;
  logic [HCOUNT_W-1:0] hcount_in;
  logic [VCOUNT_W-1:0] vcount_in;
  logic                data_valid_in;
  logic                pixel_in;
  logic                pixel_out;
  logic [HCOUNT_W-1:0] hcount_out;
  logic [VCOUNT_W-1:0] vcount_out;
  logic                data_valid_out;
`ifdef MORPH_STATS_EN
  logic [FG_COUNT_W-1:0] fg_count_out;
  logic                  count_valid_out;
`endif

  bw_erode #(.HRES(HRES), .VRES(VRES)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .hcount_in      (hcount_in),
    .vcount_in      (vcount_in),
    .data_valid_in  (data_valid_in),
    .pixel_in       (pixel_in),
    .pixel_out      (pixel_out),
    .hcount_out     (hcount_out),
    .vcount_out     (vcount_out),
    .data_valid_out (data_valid_out)
`ifdef MORPH_STATS_EN
    ,
    .fg_count_out    (fg_count_out),
    .count_valid_out (count_valid_out)
`endif
  );

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Scoreboard
  typedef struct {
    int h;
    int v;
    int pix;
    int cyc;
    bit any;   // value may legitimately be 0 while the window refills
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    int lo;
    int hi;
  } stat_t;
  stat_t stat_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int rst_chk_cyc = -1;
  bit started = 1'b0;

  int img [VRES][HRES];
  int lo_acc, hi_acc, post_rst;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: erosion straight from the image definition.
  function automatic int ref_pix(input int h, input int v);
    int a;
    if (h == 0 || v == 0) return 0;
    a = 1;
    for (int dv = -1; dv <= 1; dv++)
      for (int dh = -1; dh <= 1; dh++)
        a = a & img[v+dv][h+dh];
    return a;
  endfunction

  // Frame generators
  task automatic fill_const(input int val);
    for (int v = 0; v < VRES; v++)
      for (int h = 0; h < HRES; h++)
        img[v][h] = val;
  endtask

  task automatic fill_random();
    for (int v = 0; v < VRES; v++)
      for (int h = 0; h < HRES; h++)
        img[v][h] = ($urandom_range(3, 0) != 0) ? 1 : 0;
  endtask

  // Driver
  task automatic drive(input int h, input int v, input bit do_rst);
    exp_t e;
    stat_t s;
    hcount_in     = HCOUNT_W'(h);
    vcount_in     = VCOUNT_W'(v);
    pixel_in      = img[v][h][0];
    data_valid_in = 1'b1;
    rst_in        = do_rst;
    if (h == 0 && v == 0) begin
      lo_acc = 0;
      hi_acc = 0;
    end
    if (!do_rst && h >= 1 && v >= 1) begin
      e.h   = h - 1;
      e.v   = v - 1;
      e.pix = ref_pix(h - 1, v - 1);
      e.cyc = cyc + 2;
      e.any = (post_rst > 0);
      if (post_rst > 0) post_rst--;
      exp_q.push_back(e);
      if (e.pix == 1) begin
        hi_acc++;
        if (!e.any) lo_acc++;
      end
      if (h == HRES - 1 && v == VRES - 1) begin
        s.lo = lo_acc;
        s.hi = hi_acc;
        stat_q.push_back(s);
      end
    end
    @(posedge clk_in);
    #1;
    data_valid_in = 1'b0;
    rst_in        = 1'b0;
    if (do_rst) begin
      // Everything still in flight at the reset edge is dropped.
      exp_q.delete();
      lo_acc      = 0;
      hi_acc      = 0;
      post_rst    = 2;
      rst_chk_cyc = cyc;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  // gap_mode: 0 back-to-back, 1 idle after every beat, 2 random idles
  task automatic send_frame(input int gap_mode, input int rst_h, input int rst_v);
    for (int v = 0; v < VRES; v++) begin
      for (int h = 0; h < HRES; h++) begin
        drive(h, v, (h == rst_h) && (v == rst_v));
        if (gap_mode == 1) idle(1);
        else if (gap_mode == 2) idle($urandom_range(2, 0));
      end
    end
  endtask

  // Monitor
  always @(negedge clk_in) begin
    exp_t e;
    stat_t s;
    if (started) begin
      if (cyc == rst_chk_cyc) begin
        chk("reset_valid", int'(data_valid_out), 0);
        chk("reset_pixel", int'(pixel_out), 0);
        chk("reset_hcount", int'(hcount_out), 0);
        chk("reset_vcount", int'(vcount_out), 0);
`ifdef MORPH_STATS_EN
        chk("reset_fg_count", int'(fg_count_out), 0);
        chk("reset_count_valid", int'(count_valid_out), 0);
`endif
      end
      if (data_valid_out) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL spurious_output: got valid at (%0d,%0d) expected none (cycle %0d)",
                   hcount_out, vcount_out, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("hcount_out", int'(hcount_out), e.h);
          chk("vcount_out", int'(vcount_out), e.v);
          chk("latency_cycle", cyc, e.cyc);
          if (e.any) begin
            n_tests++;
            if (!(int'(pixel_out) == 0 || int'(pixel_out) == e.pix)) begin
              n_fail++;
              $display("FAIL pixel_refill (%0d,%0d): got %0d expected 0 or %0d",
                       e.h, e.v, pixel_out, e.pix);
            end
          end else begin
            chk($sformatf("pixel_out(%0d,%0d)", e.h, e.v), int'(pixel_out), e.pix);
          end
        end
      end
`ifdef MORPH_STATS_EN
      if (count_valid_out) begin
        chk("count_with_valid", int'(data_valid_out), 1);
        n_tests++;
        if (stat_q.size() == 0) begin
          n_fail++;
          $display("FAIL spurious_count: got count_valid with %0d expected none", fg_count_out);
        end else begin
          s = stat_q.pop_front();
          if (int'(fg_count_out) < s.lo || int'(fg_count_out) > s.hi) begin
            n_fail++;
            $display("FAIL fg_count: got %0d expected %0d..%0d", fg_count_out, s.lo, s.hi);
          end
        end
      end
`endif
    end
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Main sequence
  initial begin
    rst_in        = 1'b1;
    hcount_in     = '0;
    vcount_in     = '0;
    data_valid_in = 1'b0;
    pixel_in      = 1'b0;
    lo_acc        = 0;
    hi_acc        = 0;
    post_rst      = 0;
    repeat (3) @(posedge clk_in);
    #1;
    rst_in      = 1'b0;
    started     = 1'b1;
    rst_chk_cyc = cyc;
    idle(2);

    // All ones: interior centres 1, border centres 0, 24 foreground.
    fill_const(1);
    send_frame(0, -1, -1);

    // Single isolated foreground pixel erodes away.
    fill_const(0);
    img[2][3] = 1;
    send_frame(0, -1, -1);

    // 3x3 block survives only at its centre.
    fill_const(0);
    for (int v = 1; v <= 3; v++)
      for (int h = 2; h <= 4; h++)
        img[v][h] = 1;
    send_frame(0, -1, -1);

    // All ones with an idle cycle after every beat.
    fill_const(1);
    send_frame(1, -1, -1);

    // All ones with a reset pulse on input (4,3), then a clean frame.
    send_frame(0, 4, 3);
    idle(3);
    send_frame(0, -1, -1);

    // Random content with random gaps.
    for (int f = 0; f < 4; f++) begin
      fill_random();
      send_frame(2, -1, -1);
    end

    // Drain
    idle(6);
    chk("exp_queue_empty", exp_q.size(), 0);
`ifdef MORPH_STATS_EN
    chk("stat_queue_empty", stat_q.size(), 0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
